// File: rtl/scan_buffer_ctrl.sv
// scan_buffer_ctrl: image-buffer model that sits behind the scanner FSM.
// Fills at one unit per TICK_DIV clocks while the scanner is active, raises
// peer level flags, drains to the host over valid/ready, flushes on request.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   scanner_state     scanner FSM state (001 = active)
//   start_xfer        host drain request (level sampled)
//   flush_req         clear the buffer
//   xfer_ready        host accepts the current beat
//   xfer_valid        beat available (DRAIN only)
//   xfer_data         beat index, 0..level-1 in order
//   level             current fill level
//   wake_peer         level >= WAKE_LVL
//   handoff           level >= HANDOFF_LVL
//   full              level == CAP
//   xfer_done         one-cycle pulse after the last beat is accepted
module scan_buffer_ctrl #(
  parameter int unsigned CAP         = 100,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned WAKE_LVL    = 50,
  parameter int unsigned HANDOFF_LVL = 90,
  parameter int unsigned LVL_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       scanner_state,
  input  logic             start_xfer,
  input  logic             flush_req,
  input  logic             xfer_ready,
  output logic             xfer_valid,
  output logic [LVL_W-1:0] xfer_data,
  output logic [LVL_W-1:0] level,
  output logic             wake_peer,
  output logic             handoff,
  output logic             full,
  output logic             xfer_done
);

  localparam int unsigned DIV_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_EMPTY   = 3'd0;
  localparam logic [2:0] S_FILLING = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;

  localparam logic [2:0] SCN_ACTIVE = 3'b001;

  localparam logic [LVL_W-1:0] LVL_CAP  = LVL_W'(CAP);
  localparam logic [LVL_W-1:0] LVL_WAKE = LVL_W'(WAKE_LVL);
  localparam logic [LVL_W-1:0] LVL_HAND = LVL_W'(HANDOFF_LVL);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [2:0]       state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;

  logic             active;
  logic             beat;
  logic             at_cap;
  logic             lvl_zero;
  logic [LVL_W-1:0] lvl_inc;

  assign active   = (scanner_state == SCN_ACTIVE);
  assign beat     = (state_q == S_DRAIN) && xfer_ready;
  assign at_cap   = (level_q == LVL_CAP);
  assign lvl_zero = (level_q == '0);
  assign lvl_inc  = level_q + LVL_ONE;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    div_d   = div_q;
    done_d  = 1'b0;

    if (flush_req) begin
      // A beat already handshaking this cycle still
      // counts; the flush just suppresses xfer_done.
      state_d = S_CLEAR;
      if (beat && !lvl_zero) begin
        level_d = level_q - LVL_ONE;
        idx_d   = idx_q + LVL_ONE;
      end
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (active) begin
            state_d = S_FILLING;
            div_d   = '0;
          end
        end

        S_FILLING: begin
          if (!active) begin
            // Partial count is dropped on resume,
            // so div_q is simply left as is here.
            state_d = S_HOLD;
          end else if (at_cap) begin
            state_d = S_HOLD;
          end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            level_d = lvl_inc;
            if (lvl_inc == LVL_CAP) begin
              state_d = S_HOLD;
            end
          end else begin
            div_d = div_q + DIV_ONE;
          end
        end

        S_HOLD: begin
          // Host request outranks resuming the fill.
          if (start_xfer) begin
            if (lvl_zero) begin
              state_d = S_EMPTY;
            end else begin
              state_d = S_DRAIN;
              idx_d   = '0;
            end
          end else if (active && !at_cap) begin
            state_d = S_FILLING;
            div_d   = '0;
          end
        end

        S_DRAIN: begin
          if (beat) begin
            if (lvl_zero) begin
              state_d = S_EMPTY;
            end else begin
              level_d = level_q - LVL_ONE;
              idx_d   = idx_q + LVL_ONE;
              if (level_q == LVL_ONE) begin
                state_d = S_EMPTY;
                done_d  = 1'b1;
              end
            end
          end
        end

        S_CLEAR: begin
          level_d = '0;
          idx_d   = '0;
          div_d   = '0;
          state_d = S_EMPTY;
        end

        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      level_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  // Decoded from registered state so that an
  // asynchronous reset drops the beat at once.
  assign xfer_valid = (state_q == S_DRAIN);
  assign xfer_data  = idx_q;
  assign level      = level_q;
  assign wake_peer  = (level_q >= LVL_WAKE);
  assign handoff    = (level_q >= LVL_HAND);
  assign full       = at_cap;
  assign xfer_done  = done_q;

endmodule
